// File: rtl/sfilt_pkg.sv
// ============================================================================
// Module : sfilt_pkg
// Brief  : Shared widths, filter command encodings and sequencer states.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package sfilt_pkg;

    localparam int c_DATA_W  = 32;
    localparam int c_SHIFT_W = 7;

    localparam logic [1:0] CMD_FIRST = 2'd0;
    localparam logic [1:0] CMD_MAC   = 2'd1;
    localparam logic [1:0] CMD_SHIFT = 2'd2;
    localparam logic [1:0] CMD_OUT   = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FIRST = 3'd1,
        ST_MAC   = 3'd2,
        ST_SHIFT = 3'd3,
        ST_OUT   = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sfilt_dline.sv
// ============================================================================
// Module : sfilt_dline
// Brief  : NTAPS-deep circular sample delay line with x(k) = buf[wp-k] read.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sfilt_dline
    import sfilt_pkg::*;
#(
    parameter int NTAPS = 8,
    parameter int AW    = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [c_DATA_W-1:0] wdata,
    input  logic                adv,
    input  logic                clr,
    input  logic [AW-1:0]       rd_k,
    output logic [c_DATA_W-1:0] rd_data
);

    logic [c_DATA_W-1:0] r_buf [NTAPS];
    logic [AW-1:0]       r_wp;
    logic [AW-1:0]       w_rd_idx;
    logic [AW:0]         w_wp_ext;
    logic [AW:0]         w_k_ext;

    assign w_wp_ext = {1'b0, r_wp};
    assign w_k_ext  = {1'b0, rd_k};

    // Modular subtraction that also works when NTAPS is not a power of two.
    assign w_rd_idx = (r_wp >= rd_k) ? AW'(w_wp_ext - w_k_ext)
                                     : AW'(w_wp_ext + (AW+1)'(NTAPS) - w_k_ext);
    assign rd_data  = r_buf[w_rd_idx];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int i = 0; i < NTAPS; i++) begin
                r_buf[i] <= '0;
            end
            r_wp <= '0;
        end else begin
            if (we) begin
                r_buf[r_wp] <= wdata;
            end
            if (adv) begin
                r_wp <= (r_wp == AW'(NTAPS - 1)) ? '0 : r_wp + AW'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sfilt_seq.sv
// ============================================================================
// Module : sfilt_seq
// Brief  : FIR command sequencer feeding the serial filter's push interface.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sfilt_seq
    import sfilt_pkg::*;
#(
    parameter int NTAPS = 8,
    parameter int AW    = (NTAPS > 1) ? $clog2(NTAPS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic signed [c_DATA_W-1:0]  s_data,
    input  logic                        cfg_we,
    input  logic [AW-1:0]               cfg_addr,
    input  logic signed [c_DATA_W-1:0]  cfg_data,
    input  logic [c_SHIFT_W-1:0]        cfg_shift,
    output logic                        cfg_err,
    input  logic                        clear,
    output logic                        f_pushin,
    output logic [1:0]                  f_cmd,
    output logic [c_DATA_W-1:0]         f_q,
    output logic [c_DATA_W-1:0]         f_h,
    output logic                        busy
);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [AW-1:0]          r_k;
    logic [AW-1:0]          w_k_nxt;
    logic [c_SHIFT_W-1:0]   r_shift;
    logic [c_DATA_W-1:0]    r_coef [NTAPS];

    logic                   w_idle;
    logic                   w_accept;
    logic                   w_cfg_ok;
    logic                   w_dl_adv;
    logic                   w_dl_clr;
    logic [c_DATA_W-1:0]    w_x;
    logic [c_DATA_W-1:0]    w_coef0;

    logic                   w_push_nxt;
    logic [1:0]             w_cmd_nxt;
    logic [c_DATA_W-1:0]    w_q_nxt;
    logic [c_DATA_W-1:0]    w_h_nxt;

    assign w_idle   = (r_state == ST_IDLE);
    assign s_ready  = (w_idle && !clear) || (r_state == ST_OUT);
    assign w_accept = s_valid && s_ready;
    assign busy     = !w_idle;
    assign w_cfg_ok = cfg_we && w_idle && ({1'b0, cfg_addr} < (AW+1)'(NTAPS));
    assign w_dl_adv = (r_state == ST_SHIFT);
    assign w_dl_clr = clear && w_idle;

    // Tap 0 is registered on the write edge itself, so forward a same-cycle write.
    assign w_coef0  = (w_cfg_ok && (cfg_addr == '0)) ? cfg_data : r_coef[0];

    sfilt_dline #(
        .NTAPS (NTAPS),
        .AW    (AW)
    ) u_dline (
        .clk     (clk),
        .rst     (rst),
        .we      (w_accept),
        .wdata   (s_data),
        .adv     (w_dl_adv),
        .clr     (w_dl_clr),
        .rd_k    (w_k_nxt),
        .rd_data (w_x)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_k     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_push_nxt  = 1'b0;
        w_cmd_nxt   = f_cmd;
        w_q_nxt     = f_q;
        w_h_nxt     = f_h;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_FIRST;
                    w_k_nxt     = '0;
                end
            end
            ST_FIRST: begin
                w_state_nxt = (NTAPS == 1) ? ST_SHIFT : ST_MAC;
                w_k_nxt     = AW'(1);
            end
            ST_MAC: begin
                if (r_k == AW'(NTAPS - 1)) begin
                    w_state_nxt = ST_SHIFT;
                end else begin
                    w_k_nxt = r_k + AW'(1);
                end
            end
            ST_SHIFT: begin
                w_state_nxt = ST_OUT;
            end
            ST_OUT: begin
                if (w_accept) begin
                    w_state_nxt = ST_FIRST;
                    w_k_nxt     = '0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Outputs are registered, so they encode the push of the state being entered.
        case (w_state_nxt)
            ST_FIRST: begin
                w_push_nxt = 1'b1;
                w_cmd_nxt  = CMD_FIRST;
                w_q_nxt    = s_data;
                w_h_nxt    = w_coef0;
            end
            ST_MAC: begin
                w_push_nxt = 1'b1;
                w_cmd_nxt  = CMD_MAC;
                w_q_nxt    = w_x;
                w_h_nxt    = r_coef[w_k_nxt];
            end
            ST_SHIFT: begin
                w_push_nxt = 1'b1;
                w_cmd_nxt  = CMD_SHIFT;
                w_q_nxt    = '0;
                w_h_nxt    = {{(c_DATA_W - c_SHIFT_W){1'b0}}, r_shift};
            end
            ST_OUT: begin
                w_push_nxt = 1'b1;
                w_cmd_nxt  = CMD_OUT;
                w_q_nxt    = '0;
                w_h_nxt    = '0;
            end
            default: begin
                w_push_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            f_pushin <= 1'b0;
            f_cmd    <= '0;
            f_q      <= '0;
            f_h      <= '0;
        end else begin
            f_pushin <= w_push_nxt;
            f_cmd    <= w_cmd_nxt;
            f_q      <= w_q_nxt;
            f_h      <= w_h_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NTAPS; i++) begin
                r_coef[i] <= '0;
            end
            r_shift <= '0;
            cfg_err <= 1'b0;
        end else begin
            if (w_cfg_ok) begin
                r_coef[cfg_addr] <= cfg_data;
            end
            if (w_accept) begin
                r_shift <= cfg_shift;
            end
            cfg_err <= cfg_we && !w_idle;
        end
    end

endmodule

`default_nettype wire
